// File: rtl/adc_seq_pkg.sv
// Shared definitions for the ADC channel sequencer: FSM encoding,
// register map and register bit positions.
package adc_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SELECT,
      ST_SETTLE,
      ST_CONVERT,
      ST_WAIT,
      ST_EMIT
   } state_t;

   localparam logic [15:0] ADR_CTRL   = 16'd0;
   localparam logic [15:0] ADR_EN_LO  = 16'd1;
   localparam logic [15:0] ADR_EN_HI  = 16'd2;
   localparam logic [15:0] ADR_SETTLE = 16'd3;
   localparam logic [15:0] ADR_STATUS = 16'd4;
   localparam logic [15:0] ADR_SWEEPS = 16'd5;

   localparam int CTRL_RUN     = 0;
   localparam int CTRL_TRIG    = 1;
   localparam int STAT_BUSY    = 0;
   localparam int STAT_TIMEOUT = 1;
   localparam int STAT_CH_LSB  = 8;

endpackage

// File: rtl/adc_sequencer_if.sv
// Wishbone slave port plus ADC macro handshake and result stream of the sequencer.
interface adc_sequencer_if;
   logic        wb_cyc_i;
   logic        wb_stb_i;
   logic        wb_we_i;
   logic [15:0] wb_adr_i;
   logic [15:0] wb_dat_i;
   logic [15:0] wb_dat_o;
   logic        wb_ack_o;
   logic [4:0]  adc_chnum;
   logic        adc_start;
   logic        adc_done;
   logic [11:0] adc_data;
   logic        adc_strb;
   logic [4:0]  adc_channel;
   logic [11:0] adc_result;

   modport slave (
      input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, adc_done, adc_data,
      output wb_dat_o, wb_ack_o, adc_chnum, adc_start, adc_strb, adc_channel, adc_result
   );

   modport master (
      output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, adc_done, adc_data,
      input  wb_dat_o, wb_ack_o, adc_chnum, adc_start, adc_strb, adc_channel, adc_result
   );
endinterface

// File: rtl/adc_seq_pick.sv
// Rotated priority encoder: first enabled channel at or after the pointer,
// wrapping 31 -> 0; wrapped flags that the search went past channel 31.
module adc_seq_pick
   import adc_seq_pkg::*;
(
   input  logic [31:0] i_mask,
   input  logic [4:0]  i_ptr,
   output logic [4:0]  o_chan,
   output logic        o_valid,
   output logic        o_wrapped
);

   logic [31:0] w_rot;
   logic [4:0]  w_off;

   generate
      for (genvar gi = 0; gi < 32; gi++) begin : g_rot
         assign w_rot[gi] = i_mask[i_ptr + 5'(gi)];
      end
   endgenerate

   always_comb begin
      w_off = '0;
      for (int k = 31; k >= 0; k--) begin
         if (w_rot[k]) w_off = 5'(k);
      end
   end

   assign o_valid   = |i_mask;
   assign o_chan    = i_ptr + w_off;
   assign o_wrapped = o_valid && (o_chan < i_ptr);

endmodule

// File: rtl/adc_sequencer.sv
// Sweeps the monitor ADC over the enabled channels and streams results,
// with a Wishbone register file for run control, masks, settle time and status.
module adc_sequencer
   import adc_seq_pkg::*;
#(
   parameter logic [15:0] SETTLE_DEFAULT = 16'd50,
   parameter logic [15:0] TIMEOUT        = 16'd1000
) (
   input  logic            wb_clk_i,
   input  logic            wb_rst_i,
   input  logic            soft_reset,
   adc_sequencer_if.slave  bus
);

   state_t      r_state, w_state_next;
   logic        r_run, r_trig, r_tmo, r_skip, r_ack;
   logic [15:0] r_en_lo, r_en_hi, r_settle, r_sweeps, r_cnt, r_dat;
   logic [4:0]  r_ptr, r_chan;
   logic [11:0] r_result;

   logic        w_req, w_wr, w_busy, w_timeout, w_sweep_done, w_trig_set;
   logic        w_pick_valid, w_pick_wrapped;
   logic [4:0]  w_pick_ptr, w_pick_chan;
   logic [15:0] w_rd_data;

   assign w_req      = bus.wb_cyc_i && bus.wb_stb_i && !r_ack;
   assign w_wr       = w_req && bus.wb_we_i;
   assign w_busy     = (r_state != ST_IDLE);
   assign w_timeout  = (r_state == ST_WAIT) && !bus.adc_done && (r_cnt == TIMEOUT);
   assign w_trig_set = w_wr && (bus.wb_adr_i == ADR_CTRL) && bus.wb_dat_i[CTRL_TRIG];

   // In EMIT the encoder looks ahead from channel+1 to decide if the sweep is over.
   assign w_pick_ptr   = (r_state == ST_EMIT) ? r_chan + 5'd1 : r_ptr;
   assign w_sweep_done = !w_pick_valid || w_pick_wrapped || (r_chan == 5'd31);

   adc_seq_pick u_pick (
      .i_mask    ({r_en_hi, r_en_lo}),
      .i_ptr     (w_pick_ptr),
      .o_chan    (w_pick_chan),
      .o_valid   (w_pick_valid),
      .o_wrapped (w_pick_wrapped)
   );

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) r_state <= ST_IDLE;
      else          r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:    if ((r_run || r_trig) && w_pick_valid) w_state_next = ST_SELECT;
         ST_SELECT:  w_state_next = w_pick_valid ? ST_SETTLE : ST_IDLE;
         ST_SETTLE:  if (r_cnt <= 16'd1) w_state_next = ST_CONVERT;
         ST_CONVERT: w_state_next = ST_WAIT;
         ST_WAIT:    if (bus.adc_done || w_timeout) w_state_next = ST_EMIT;
         ST_EMIT:    w_state_next = (r_run || (r_trig && !w_sweep_done)) ? ST_SELECT : ST_IDLE;
         default:    w_state_next = ST_IDLE;
      endcase
      if (soft_reset) w_state_next = ST_IDLE;
   end

   always_comb begin
      bus.adc_start = 1'b0;
      bus.adc_strb  = 1'b0;
      bus.adc_chnum = r_chan;
      case (r_state)
         ST_SELECT:  bus.adc_chnum = w_pick_chan;
         ST_CONVERT: bus.adc_start = 1'b1;
         ST_EMIT:    bus.adc_strb  = !r_skip;
         default:    ;
      endcase
   end

   assign bus.adc_channel = r_chan;
   assign bus.adc_result  = r_result;
   assign bus.wb_ack_o    = r_ack;
   assign bus.wb_dat_o    = r_dat;

   always_comb begin
      w_rd_data = '0;
      case (bus.wb_adr_i)
         ADR_CTRL:   w_rd_data = {14'd0, r_trig, r_run};
         ADR_EN_LO:  w_rd_data = r_en_lo;
         ADR_EN_HI:  w_rd_data = r_en_hi;
         ADR_SETTLE: w_rd_data = r_settle;
         ADR_STATUS: w_rd_data = {3'd0, r_chan, 6'd0, r_tmo, w_busy};
         ADR_SWEEPS: w_rd_data = r_sweeps;
         default:    w_rd_data = '0;
      endcase
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_ack    <= 1'b0;
         r_dat    <= '0;
         r_run    <= 1'b0;
         r_trig   <= 1'b0;
         r_en_lo  <= 16'hFFFF;
         r_en_hi  <= 16'hFFFF;
         r_settle <= SETTLE_DEFAULT;
         r_tmo    <= 1'b0;
         r_skip   <= 1'b0;
         r_sweeps <= '0;
         r_cnt    <= '0;
         r_ptr    <= '0;
         r_chan   <= '0;
         r_result <= '0;
      end else begin
         r_ack <= w_req;
         r_dat <= (w_req && !bus.wb_we_i) ? w_rd_data : 16'd0;

         // A fresh TRIG write in the same cycle beats the end-of-sweep clear.
         if (r_state == ST_EMIT && w_sweep_done && !soft_reset && !w_trig_set) r_trig <= 1'b0;
         if (w_wr) begin
            case (bus.wb_adr_i)
               ADR_CTRL: begin
                  r_run <= bus.wb_dat_i[CTRL_RUN];
                  if (bus.wb_dat_i[CTRL_TRIG]) r_trig <= 1'b1;
               end
               ADR_EN_LO:  r_en_lo  <= bus.wb_dat_i;
               ADR_EN_HI:  r_en_hi  <= bus.wb_dat_i;
               ADR_SETTLE: r_settle <= bus.wb_dat_i;
               default:    ;
            endcase
         end

         if (soft_reset) begin
            r_ptr  <= '0;
            r_tmo  <= 1'b0;
            r_skip <= 1'b0;
         end else begin
            if (w_wr && bus.wb_adr_i == ADR_STATUS) r_tmo <= 1'b0;
            case (r_state)
               ST_SELECT: begin
                  if (w_pick_valid) r_chan <= w_pick_chan;
                  r_cnt <= (r_settle == 16'd0) ? 16'd1 : r_settle;
               end
               ST_SETTLE:  r_cnt <= r_cnt - 16'd1;
               ST_CONVERT: begin
                  r_cnt  <= '0;
                  r_skip <= 1'b0;
               end
               ST_WAIT: begin
                  r_cnt <= r_cnt + 16'd1;
                  if (bus.adc_done) begin
                     r_result <= bus.adc_data;
                  end else if (w_timeout) begin
                     r_tmo  <= 1'b1;
                     r_skip <= 1'b1;
                  end
               end
               ST_EMIT: begin
                  r_ptr <= r_chan + 5'd1;
                  if (w_sweep_done) r_sweeps <= r_sweeps + 16'd1;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_adc_sequencer.sv
// Directed bench for adc_sequencer: ADC model with fixed 5-cycle conversion,
// strobe/start monitor and Wishbone register accesses.
module tb_adc_sequencer;
   import adc_seq_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic soft_rst = 1'b0;

   adc_sequencer_if bus ();

   adc_sequencer dut (
      .wb_clk_i   (clk),
      .wb_rst_i   (rst),
      .soft_reset (soft_rst),
      .bus        (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
   endtask

   function automatic logic [11:0] f_res(input logic [4:0] ch);
      return 12'h400 + 12'(ch) * 12'd5;
   endfunction

   // ADC model: done five cycles after a sampled start, unless the channel is ignored
   logic       ign_en = 1'b0;
   logic [4:0] ign_ch = 5'd3;
   int         pend = 0;
   int         dcnt = 0;
   logic [4:0] pch  = 5'd0;

   always @(negedge clk) begin
      if (rst) begin
         bus.adc_done = 1'b0;
         bus.adc_data = 12'd0;
         pend = 0;
      end else begin
         bus.adc_done = 1'b0;
         if (pend != 0) begin
            if (dcnt == 1) begin
               bus.adc_done = 1'b1;
               bus.adc_data = f_res(pch);
               pend = 0;
            end else begin
               dcnt--;
            end
         end
         if (bus.adc_start && !(ign_en && bus.adc_chnum == ign_ch)) begin
            pend = 1;
            dcnt = 5;
            pch  = bus.adc_chnum;
         end
      end
   end

   // Monitor
   int         cyc = 0, n_strb = 0, n_start = 0, last_strb_cyc = 0, last_gap = 0;
   logic [4:0] s_ch[$];
   logic [11:0] s_res[$];

   always @(negedge clk) begin
      cyc++;
      if (!rst) begin
         if (bus.adc_strb) begin
            s_ch.push_back(bus.adc_channel);
            s_res.push_back(bus.adc_result);
            n_strb++;
            last_strb_cyc = cyc;
            $display("strobe #%0d ch=%0d result=0x%03h", n_strb, bus.adc_channel, bus.adc_result);
         end
         if (bus.adc_start) begin
            n_start++;
            last_gap = cyc - last_strb_cyc;
         end
      end
   end

   task automatic wb_xfer(input logic we, input logic [15:0] adr, input logic [15:0] wdat,
                          output logic [15:0] rdat);
      int n;
      n = 0;
      @(negedge clk);
      bus.wb_cyc_i = 1'b1;
      bus.wb_stb_i = 1'b1;
      bus.wb_we_i  = we;
      bus.wb_adr_i = adr;
      bus.wb_dat_i = wdat;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.wb_ack_o && n < 8);
      if (!bus.wb_ack_o) chk("wb_ack_wait", {31'd0, bus.wb_ack_o}, 32'd1);
      rdat = bus.wb_dat_o;
      bus.wb_cyc_i = 1'b0;
      bus.wb_stb_i = 1'b0;
      bus.wb_we_i  = 1'b0;
      $display("wb %s adr=%0d data=0x%04h", we ? "wr" : "rd", adr, we ? wdat : rdat);
   endtask

   task automatic wb_write(input logic [15:0] adr, input logic [15:0] wdat);
      logic [15:0] dummy;
      wb_xfer(1'b1, adr, wdat, dummy);
   endtask

   task automatic wb_read(input logic [15:0] adr, output logic [15:0] rdat);
      wb_xfer(1'b0, adr, 16'd0, rdat);
   endtask

   task automatic wait_strb(input int target, input int budget, input string tag);
      int n;
      n = 0;
      while (n_strb < target && n < budget) begin
         @(posedge clk);
         n++;
      end
      if (n_strb < target) chk(tag, n_strb, target);
   endtask

   task automatic wait_idle(input string tag);
      logic [15:0] st;
      int n;
      n = 0;
      wb_read(ADR_STATUS, st);
      while (st[STAT_BUSY] && n < 200) begin
         wb_read(ADR_STATUS, st);
         n++;
      end
      if (st[STAT_BUSY]) chk(tag, {31'd0, st[STAT_BUSY]}, 32'd0);
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin : main
      logic [15:0] rd;
      int base, st0, n;

      bus.wb_cyc_i = 1'b0;
      bus.wb_stb_i = 1'b0;
      bus.wb_we_i  = 1'b0;
      bus.wb_adr_i = 16'd0;
      bus.wb_dat_i = 16'd0;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_outputs", {bus.wb_dat_o, bus.wb_ack_o, bus.adc_chnum, bus.adc_start,
                          bus.adc_strb, bus.adc_channel, bus.adc_result}, 32'd0);
      rst = 1'b0;
      wb_read(ADR_CTRL, rd);    chk("rst_ctrl", rd, 16'h0000);
      wb_read(ADR_EN_LO, rd);   chk("rst_en_lo", rd, 16'hFFFF);
      wb_read(ADR_EN_HI, rd);   chk("rst_en_hi", rd, 16'hFFFF);
      wb_read(ADR_SETTLE, rd);  chk("rst_settle", rd, 16'd50);
      wb_read(ADR_STATUS, rd);  chk("rst_status", rd, 16'h0000);
      wb_read(ADR_SWEEPS, rd);  chk("rst_sweeps", rd, 16'h0000);
      wb_write(16'd7, 16'h1234);
      wb_read(16'd7, rd);       chk("unmapped_read", rd, 16'h0000);

      // Full sweep with defaults and RUN
      wb_write(ADR_CTRL, 16'h0001);
      wait_strb(32, 32 * 80, "wait_sweep1");
      for (int i = 0; i < 32; i++) begin
         if (i < s_ch.size())
            chk("sweep1_res_ch", {s_res[i], s_ch[i]}, {15'd0, f_res(5'(i)), 5'(i)});
      end
      wb_read(ADR_SWEEPS, rd);  chk("sweeps_after_1", rd, 16'd1);
      wait_strb(33, 100, "wait_sweep2_start");
      if (s_ch.size() > 32) chk("sweep2_first_ch", s_ch[32], 5'd0);
      chk("gap_settle50", last_gap, 32'd52);
      wb_write(ADR_CTRL, 16'h0000);
      wait_idle("idle_after_run");
      chk("run_stop_count", n_strb, 34);
      @(negedge clk); soft_rst = 1'b1;
      @(negedge clk); soft_rst = 1'b0;
      wb_read(ADR_STATUS, rd);  chk("softrst_busy", {31'd0, rd[STAT_BUSY]}, 32'd0);

      // Single triggered sweep on ch0 and ch2
      base = n_strb;
      wb_write(ADR_EN_LO, 16'h0005);
      wb_write(ADR_EN_HI, 16'h0000);
      wb_write(ADR_CTRL, 16'h0002);
      wait_strb(base + 2, 400, "wait_trig");
      repeat (20) @(posedge clk);
      chk("trig_count", n_strb, base + 2);
      if (s_ch.size() >= base + 2) begin
         chk("trig_ch_a", {s_res[base], s_ch[base]}, {15'd0, f_res(5'd0), 5'd0});
         chk("trig_ch_b", {s_res[base+1], s_ch[base+1]}, {15'd0, f_res(5'd2), 5'd2});
      end
      wb_read(ADR_SWEEPS, rd);  chk("trig_sweeps", rd, 16'd2);
      wb_read(ADR_CTRL, rd);    chk("trig_selfclear", rd, 16'h0000);
      wb_read(ADR_STATUS, rd);  chk("trig_idle", {31'd0, rd[STAT_BUSY]}, 32'd0);

      // SETTLE=10, pointer at 3 so the search wraps to ch0
      base = n_strb;
      wb_write(ADR_SETTLE, 16'd10);
      wb_write(ADR_CTRL, 16'h0002);
      wait_strb(base + 2, 300, "wait_settle10");
      if (s_ch.size() >= base + 2) begin
         chk("wrap_pick_ch0", s_ch[base], 5'd0);
         chk("settle10_ch2", s_ch[base+1], 5'd2);
      end
      chk("gap_settle10", last_gap, 32'd12);
      wb_read(ADR_SWEEPS, rd);  chk("settle10_sweeps", rd, 16'd3);

      // Timeout on ch3, ch4 still converts
      base = n_strb;
      wb_write(ADR_EN_LO, 16'h0018);
      ign_en = 1'b1;
      wb_write(ADR_CTRL, 16'h0002);
      wait_strb(base + 1, 1500, "wait_timeout");
      repeat (20) @(posedge clk);
      chk("timeout_count", n_strb, base + 1);
      if (s_ch.size() >= base + 1) chk("timeout_next_ch", s_ch[base], 5'd4);
      wb_read(ADR_STATUS, rd);  chk("timeout_sticky", {31'd0, rd[STAT_TIMEOUT]}, 32'd1);
      wb_write(ADR_STATUS, 16'h0000);
      wb_read(ADR_STATUS, rd);  chk("timeout_cleared", {31'd0, rd[STAT_TIMEOUT]}, 32'd0);
      ign_en = 1'b0;
      wb_read(ADR_SWEEPS, rd);  chk("timeout_sweeps", rd, 16'd4);

      // Empty mask with RUN
      st0 = n_start;
      wb_write(ADR_EN_LO, 16'h0000);
      wb_write(ADR_CTRL, 16'h0001);
      repeat (30) @(posedge clk);
      chk("mask0_no_start", n_start, st0);
      wb_read(ADR_STATUS, rd);  chk("mask0_busy", {31'd0, rd[STAT_BUSY]}, 32'd0);
      wb_write(ADR_CTRL, 16'h0000);

      // RUN dropped during ch7 settle, then resumed
      base = n_strb;
      wb_write(ADR_SETTLE, 16'd50);
      wb_write(ADR_EN_LO, 16'h0180);
      wb_write(ADR_CTRL, 16'h0001);
      n = 0;
      while (bus.adc_chnum != 5'd7 && n < 50) begin
         @(posedge clk);
         n++;
      end
      chk("run_sel_ch7", bus.adc_chnum, 5'd7);
      wb_write(ADR_CTRL, 16'h0000);
      wait_strb(base + 1, 200, "wait_ch7");
      repeat (100) @(posedge clk);
      chk("stop_count", n_strb, base + 1);
      if (s_ch.size() >= base + 1) chk("stop_ch7", s_ch[base], 5'd7);
      wb_read(ADR_STATUS, rd);  chk("stop_status", rd, 16'h0700);
      wb_write(ADR_CTRL, 16'h0001);
      wait_strb(base + 2, 200, "wait_resume");
      if (s_ch.size() >= base + 2) chk("resume_ch8", s_ch[base+1], 5'd8);

      // Async reset while waiting for the ADC
      st0 = n_start;
      n = 0;
      while (n_start == st0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      chk("start_before_rst", n_start, st0 + 1);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_outputs", {bus.wb_dat_o, bus.wb_ack_o, bus.adc_chnum, bus.adc_start,
                                bus.adc_strb, bus.adc_channel, bus.adc_result}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      wb_read(ADR_EN_LO, rd);   chk("post_rst_en_lo", rd, 16'hFFFF);
      wb_read(ADR_SWEEPS, rd);  chk("post_rst_sweeps", rd, 16'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
